// File: rtl/register_file_param.sv
// DEPTH x WIDTH register file: 2 registered read ports, 1 write port, hardware clear after reset.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to a matching read.
module register_file_param #(
    parameter int   WIDTH    = 8,
    parameter int   DEPTH    = 8,
    parameter int   ZERO_REG = 0,
    localparam int  ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en1_i,
    input  logic [ADDR_W-1:0] rd_addr1_i,
    input  logic              rd_en2_i,
    input  logic [ADDR_W-1:0] rd_addr2_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    output logic [WIDTH-1:0]  rd_out1_o,
    output logic [WIDTH-1:0]  rd_out2_o,
    output logic              rd_valid1_o,
    output logic              rd_valid2_o,
    output logic              wr_success_o,
    output logic              busy_o
);

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    localparam bit               HasZero = (ZERO_REG != 0);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   clrPtr_q;
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [WIDTH-1:0]    rdOut1_q, rdOut2_q;
    logic                rdValid1_q, rdValid2_q;
    logic                wrSuccess_q;
    logic                busy_q;

    logic                wrFire;
    logic                zeroHit1, zeroHit2;
    logic [WIDTH-1:0]    rdData1_d, rdData2_d;

    // Writes to a hardwired-zero register are dropped and never acknowledged.
    always_comb begin
        zeroHit1  = HasZero && (rd_addr1_i == '0);
        zeroHit2  = HasZero && (rd_addr2_i == '0);
        wrFire    = (state_q == READY) && wr_en_i && !(HasZero && (wr_addr_i == '0));
        rdData1_d = mem_q[rd_addr1_i];
        rdData2_d = mem_q[rd_addr2_i];
        if (Bypass && wrFire && (wr_addr_i == rd_addr1_i)) rdData1_d = wr_data_i;
        if (Bypass && wrFire && (wr_addr_i == rd_addr2_i)) rdData2_d = wr_data_i;
        if (zeroHit1) rdData1_d = '0;
        if (zeroHit2) rdData2_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_q[clrPtr_q] <= '0;
            end else if (wrFire) begin
                mem_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clrPtr_q    <= '0;
            rdOut1_q    <= '0;
            rdOut2_q    <= '0;
            rdValid1_q  <= 1'b0;
            rdValid2_q  <= 1'b0;
            wrSuccess_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    rdValid1_q  <= 1'b0;
                    rdValid2_q  <= 1'b0;
                    wrSuccess_q <= 1'b0;
                    clrPtr_q    <= clrPtr_q + 1'b1;
                    if (clrPtr_q == LastAddr) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end
                end
                READY: begin
                    rdValid1_q  <= rd_en1_i;
                    rdValid2_q  <= rd_en2_i;
                    wrSuccess_q <= wrFire;
                    if (rd_en1_i) rdOut1_q <= rdData1_d;
                    if (rd_en2_i) rdOut2_q <= rdData2_d;
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign rd_out1_o    = rdOut1_q;
    assign rd_out2_o    = rdOut2_q;
    assign rd_valid1_o  = rdValid1_q;
    assign rd_valid2_o  = rdValid2_q;
    assign wr_success_o = wrSuccess_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: a default instance and a ZERO_REG=1 instance share all inputs.
module tb_register_file_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdEn1, rdEn2, wrEn;
    logic [2:0] rdAddr1, rdAddr2, wrAddr;
    logic [7:0] wrData;

    logic [7:0] out1, out2, zOut1, zOut2;
    logic       valid1, valid2, wrOk, busy;
    logic       zValid1, zValid2, zWrOk, zBusy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    register_file_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst),
        .rd_en1_i(rdEn1), .rd_addr1_i(rdAddr1),
        .rd_en2_i(rdEn2), .rd_addr2_i(rdAddr2),
        .wr_en_i(wrEn), .wr_addr_i(wrAddr), .wr_data_i(wrData),
        .rd_out1_o(out1), .rd_out2_o(out2),
        .rd_valid1_o(valid1), .rd_valid2_o(valid2),
        .wr_success_o(wrOk), .busy_o(busy)
    );

    register_file_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1)) dutZero (
        .clk(clk), .rst(rst),
        .rd_en1_i(rdEn1), .rd_addr1_i(rdAddr1),
        .rd_en2_i(rdEn2), .rd_addr2_i(rdAddr2),
        .wr_en_i(wrEn), .wr_addr_i(wrAddr), .wr_data_i(wrData),
        .rd_out1_o(zOut1), .rd_out2_o(zOut2),
        .rd_valid1_o(zValid1), .rd_valid2_o(zValid2),
        .wr_success_o(zWrOk), .busy_o(zBusy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic e1, input logic [2:0] a1, input logic e2, input logic [2:0] a2,
                                 input logic we, input logic [2:0] wa, input logic [7:0] wd);
        rdEn1 = e1; rdAddr1 = a1;
        rdEn2 = e2; rdAddr2 = a2;
        wrEn  = we; wrAddr  = wa; wrData = wd;
    endtask

    initial begin
        logic [7:0] bypassExp;
        rst = 1'b1;
        applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
        tick();
        checkOutput("reset_busy", busy, 1);
        checkOutput("reset_valid1", valid1, 0);
        checkOutput("reset_out1", out1, 0);
        checkOutput("reset_wrok", wrOk, 0);
        rst = 1'b0;

        // Write at the third CLEAR edge targets an already-cleared address and must be dropped.
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) applyStimulus(1'b1, 3'd1, 1'b0, 3'd0, 1'b1, 3'd1, 8'h77);
            else        applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
            tick();
            checkOutput($sformatf("clear_busy_%0d", i), busy, (i < 8));
            if (i == 3) begin
                checkOutput("clear_wrok_ignored", wrOk, 0);
                checkOutput("clear_valid_ignored", valid1, 0);
            end
        end

        for (int a = 0; a < 8; a++) begin
            applyStimulus(1'b1, 3'(a), 1'b1, 3'(7 - a), 1'b0, 3'd0, 8'h00);
            tick();
            checkOutput($sformatf("cleared_out1_a%0d", a), out1, 0);
            checkOutput($sformatf("cleared_valid1_a%0d", a), valid1, 1);
            checkOutput($sformatf("cleared_out2_a%0d", 7 - a), out2, 0);
        end

        applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd3, 8'hA5);
        tick();
        checkOutput("wr3_wrok", wrOk, 1);
        checkOutput("wr3_valid1", valid1, 0);
        applyStimulus(1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
        tick();
        checkOutput("wr3_wrok_pulse", wrOk, 0);
        checkOutput("rd3_out1", out1, 8'hA5);
        checkOutput("rd3_valid1", valid1, 1);

        applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd5, 8'h11);
        tick();
        checkOutput("b2b_wrok_a", wrOk, 1);
        applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd2, 8'h5A);
        tick();
        checkOutput("b2b_wrok_b", wrOk, 1);

`ifdef REGFILE_BYPASS_EN
        bypassExp = 8'h3C;
`else
        bypassExp = 8'h11;
`endif
        applyStimulus(1'b0, 3'd0, 1'b1, 3'd5, 1'b1, 3'd5, 8'h3C);
        tick();
        checkOutput("rw_same_out2", out2, bypassExp);
        checkOutput("rw_same_valid2", valid2, 1);
        checkOutput("rw_same_wrok", wrOk, 1);
        applyStimulus(1'b0, 3'd0, 1'b1, 3'd5, 1'b0, 3'd0, 8'h00);
        tick();
        checkOutput("rw_commit_out2", out2, 8'h3C);

        applyStimulus(1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
        tick();
        checkOutput("p1only_valid1", valid1, 1);
        checkOutput("p1only_out1", out1, 8'h5A);
        checkOutput("p1only_valid2", valid2, 0);
        checkOutput("p1only_out2_hold", out2, 8'h3C);

        applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd0, 8'hFF);
        tick();
        checkOutput("zero_wrok", zWrOk, 0);
        checkOutput("plain_wrok_a0", wrOk, 1);
        applyStimulus(1'b1, 3'd0, 1'b1, 3'd3, 1'b0, 3'd0, 8'h00);
        tick();
        checkOutput("zero_rd0", zOut1, 0);
        checkOutput("zero_rd0_valid", zValid1, 1);
        checkOutput("zero_rd3", zOut2, 8'hA5);
        checkOutput("plain_rd0", out1, 8'hFF);
        applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b1, 3'd0, 8'h42);
        tick();
        checkOutput("zero_rw0_out1", zOut1, 0);

        // Reset from READY, then again mid-CLEAR: busy must span a full 8 cycles from the last release.
        applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
        rst = 1'b1;
        tick();
        checkOutput("rst2_busy", busy, 1);
        checkOutput("rst2_out1", out1, 0);
        rst = 1'b0;
        tick(); tick(); tick();
        checkOutput("rst2_mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
            tick();
            checkOutput($sformatf("rst3_busy_%0d", i), busy, (i < 8));
            checkOutput($sformatf("rst3_zbusy_%0d", i), zBusy, (i < 8));
            if (i == 2) checkOutput("rst3_valid_ignored", valid1, 0);
        end
        applyStimulus(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 8'h00);
        tick();
        checkOutput("rst3_rd3", out1, 0);
        checkOutput("rst3_rd0", out2, 0);
        checkOutput("rst3_valid1", valid1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
